// File: rtl/quantum_scheduler_ctrl.sv
// Preemptive time-slice controller: counts a per-process quantum, vectors the CPU to the
// kernel scheduler on expiry or yield, and keeps a saved-PC table used to resume processes.
module quantum_scheduler_ctrl #(
  parameter int NUM_PROC        = 4,
  parameter int PID_W           = 2,
  parameter int Q_W             = 16,
  parameter int DEFAULT_QUANTUM = 100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sched_enable,
  input  logic             halt,
  input  logic [31:0]      pc_atual,
  input  logic             yield,
  input  logic             resume_req,
  input  logic [PID_W-1:0] resume_pid,
  input  logic             cfg_q_we,
  input  logic [Q_W-1:0]   cfg_q,
  input  logic             pc_we,
  input  logic [PID_W-1:0] pc_sel,
  input  logic [31:0]      pc_wdata,
  output logic [31:0]      pc_rdata,
  output logic [1:0]       troca_contexto,
  output logic             resume_valid,
  output logic [31:0]      resume_pc,
  output logic [PID_W-1:0] proc_atual,
  output logic             kernel_mode,
  output logic [Q_W-1:0]   quantum_left
);

  typedef enum logic [1:0] {KERNEL, RUN, SWITCH} state_t;

  state_t         state;
  logic [31:0]    pc_table [NUM_PROC];
  logic [Q_W-1:0] q_reg;

  logic advance;
  logic expire;
  logic yield_take;

  // The counter and yield only act while scheduling is enabled and the CPU is not paused.
  assign advance    = sched_enable && !halt;
  assign expire     = advance && (quantum_left == Q_W'(1));
  assign yield_take = advance && yield;

  assign pc_rdata = pc_table[pc_sel];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= KERNEL;
      troca_contexto <= 2'b00;
      resume_valid   <= 1'b0;
      resume_pc      <= '0;
      proc_atual     <= '0;
      kernel_mode    <= 1'b1;
      quantum_left   <= '0;
      q_reg          <= Q_W'(DEFAULT_QUANTUM);
      for (int i = 0; i < NUM_PROC; i++) pc_table[i] <= '0;
    end else begin
      resume_valid <= 1'b0;

      if (cfg_q_we && (cfg_q != '0)) q_reg <= cfg_q;

      // Entry-point writes come first so a same-edge context save to that slot overrides them.
      if (pc_we) pc_table[pc_sel] <= pc_wdata;

      case (state)
        KERNEL: begin
          if (resume_req && sched_enable) begin
            proc_atual   <= resume_pid;
            resume_pc    <= pc_table[resume_pid];
            resume_valid <= 1'b1;
            quantum_left <= q_reg;
            kernel_mode  <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (expire || yield_take) begin
            quantum_left   <= '0;
            troca_contexto <= 2'b11;
            state          <= SWITCH;
          end else if (advance && (quantum_left != '0)) begin
            quantum_left <= quantum_left - Q_W'(1);
          end
        end
        SWITCH: begin
          // A paused CPU has not retired the current instruction, so it is re-executed on resume.
          pc_table[proc_atual] <= halt ? pc_atual : pc_atual + 32'd1;
          troca_contexto       <= 2'b00;
          kernel_mode          <= 1'b1;
          quantum_left         <= '0;
          state                <= KERNEL;
        end
        default: begin
          troca_contexto <= 2'b00;
          kernel_mode    <= 1'b1;
          state          <= KERNEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_scheduler_ctrl.sv
// Directed bench for quantum_scheduler_ctrl: slice timing, halt/enable gating, yield,
// context-save values, quantum config rejection and asynchronous reset mid-switch.
module tb_quantum_scheduler_ctrl;

  localparam int PID_W = 2;
  localparam int Q_W   = 16;

  logic             clock;
  logic             reset;
  logic             sched_enable;
  logic             halt;
  logic [31:0]      pc_atual;
  logic             yield;
  logic             resume_req;
  logic [PID_W-1:0] resume_pid;
  logic             cfg_q_we;
  logic [Q_W-1:0]   cfg_q;
  logic             pc_we;
  logic [PID_W-1:0] pc_sel;
  logic [31:0]      pc_wdata;
  logic [31:0]      pc_rdata;
  logic [1:0]       troca_contexto;
  logic             resume_valid;
  logic [31:0]      resume_pc;
  logic [PID_W-1:0] proc_atual;
  logic             kernel_mode;
  logic [Q_W-1:0]   quantum_left;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  quantum_scheduler_ctrl #(
    .NUM_PROC(4), .PID_W(PID_W), .Q_W(Q_W), .DEFAULT_QUANTUM(100)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sched_enable   (sched_enable),
    .halt           (halt),
    .pc_atual       (pc_atual),
    .yield          (yield),
    .resume_req     (resume_req),
    .resume_pid     (resume_pid),
    .cfg_q_we       (cfg_q_we),
    .cfg_q          (cfg_q),
    .pc_we          (pc_we),
    .pc_sel         (pc_sel),
    .pc_wdata       (pc_wdata),
    .pc_rdata       (pc_rdata),
    .troca_contexto (troca_contexto),
    .resume_valid   (resume_valid),
    .resume_pc      (resume_pc),
    .proc_atual     (proc_atual),
    .kernel_mode    (kernel_mode),
    .quantum_left   (quantum_left)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_resume(input logic [PID_W-1:0] pid);
    resume_req = 1'b1;
    resume_pid = pid;
    tick();
    resume_req = 1'b0;
  endtask

  task automatic write_q(input logic [Q_W-1:0] q);
    cfg_q_we = 1'b1;
    cfg_q    = q;
    tick();
    cfg_q_we = 1'b0;
  endtask

  // Advance until troca_contexto pulses, counting edges; bounded.
  task automatic wait_switch(input int limit, output int n);
    n = 0;
    while (troca_contexto !== 2'b11 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b0; sched_enable = 1'b1; halt = 1'b0; pc_atual = 32'h57;
    yield = 1'b0; resume_req = 1'b0; resume_pid = '0; cfg_q_we = 1'b0;
    cfg_q = '0; pc_we = 1'b0; pc_sel = 2'd2; pc_wdata = '0;
    repeat (3) tick();

    check_eq("rst_troca", 32'(troca_contexto), 32'h0);
    check_eq("rst_rvalid", 32'(resume_valid), 32'h0);
    check_eq("rst_rpc", resume_pc, 32'h0);
    check_eq("rst_proc", 32'(proc_atual), 32'h0);
    check_eq("rst_kmode", 32'(kernel_mode), 32'h1);
    check_eq("rst_qleft", 32'(quantum_left), 32'h0);
    check_eq("rst_table2", pc_rdata, 32'h0);
    reset = 1'b1;
    tick();

    // Entry point for slot 2, then default-quantum slice.
    pc_we = 1'b1; pc_sel = 2'd2; pc_wdata = 32'h40;
    tick();
    pc_we = 1'b0;
    check_eq("tbl2_wr", pc_rdata, 32'h40);
    do_resume(2'd2);
    check_eq("r1_valid", 32'(resume_valid), 32'h1);
    check_eq("r1_pc", resume_pc, 32'h40);
    check_eq("r1_proc", 32'(proc_atual), 32'h2);
    check_eq("r1_kmode", 32'(kernel_mode), 32'h0);
    check_eq("r1_qleft", 32'(quantum_left), 32'd100);
    tick();
    check_eq("r1_valid_drop", 32'(resume_valid), 32'h0);
    check_eq("r1_qleft_dec", 32'(quantum_left), 32'd99);
    wait_switch(200, cnt);
    check_eq("r1_switch_lat", 32'(cnt + 1), 32'd100);
    check_eq("r1_sw_qleft", 32'(quantum_left), 32'h0);
    check_eq("r1_sw_kmode", 32'(kernel_mode), 32'h0);
    tick();
    check_eq("r1_troca_end", 32'(troca_contexto), 32'h0);
    check_eq("r1_kmode_back", 32'(kernel_mode), 32'h1);
    check_eq("r1_saved_pc", pc_rdata, 32'h58);

    // Quantum 3, zero write rejected, 5-cycle halt stretches the slice.
    write_q(16'd3);
    write_q(16'd0);
    pc_atual = 32'h100;
    do_resume(2'd2);
    check_eq("r2_pc", resume_pc, 32'h58);
    check_eq("r2_qleft", 32'(quantum_left), 32'd3);
    tick();
    halt = 1'b1;
    repeat (5) tick();
    check_eq("r2_halt_hold", 32'(quantum_left), 32'd2);
    check_eq("r2_halt_troca", 32'(troca_contexto), 32'h0);
    halt = 1'b0;
    wait_switch(50, cnt);
    check_eq("r2_switch_lat", 32'(cnt + 6), 32'd8);
    tick();
    check_eq("r2_saved_pc", pc_rdata, 32'h101);

    // Yield on the second cycle of a slice; halted SWITCH saves pc_atual unchanged.
    do_resume(2'd1);
    check_eq("r3_pc", resume_pc, 32'h0);
    tick();
    yield = 1'b1;
    tick();
    yield = 1'b0;
    check_eq("r3_yield_troca", 32'(troca_contexto), 32'h3);
    check_eq("r3_yield_qleft", 32'(quantum_left), 32'h0);
    halt = 1'b1; pc_atual = 32'h200; pc_sel = 2'd1;
    tick();
    halt = 1'b0;
    check_eq("r3_troca_end", 32'(troca_contexto), 32'h0);
    check_eq("r3_saved_halt", pc_rdata, 32'h200);

    // Quantum 1: expiry and yield on the same edge give one pulse.
    write_q(16'd1);
    do_resume(2'd3);
    check_eq("r4_qleft", 32'(quantum_left), 32'd1);
    yield = 1'b1;
    tick();
    yield = 1'b0;
    check_eq("r4_troca", 32'(troca_contexto), 32'h3);
    pc_atual = 32'h300; pc_sel = 2'd3;
    tick();
    check_eq("r4_troca_end", 32'(troca_contexto), 32'h0);
    tick();
    check_eq("r4_no_second", 32'(troca_contexto), 32'h0);
    check_eq("r4_saved_pc", pc_rdata, 32'h301);

    // sched_enable=0 freezes counting, yield and resume.
    write_q(16'd5);
    do_resume(2'd0);
    tick();
    check_eq("r5_qleft", 32'(quantum_left), 32'd4);
    sched_enable = 1'b0;
    yield = 1'b1;
    tick();
    yield = 1'b0;
    resume_req = 1'b1; resume_pid = 2'd3;
    tick();
    resume_req = 1'b0;
    repeat (3) tick();
    check_eq("r5_frozen", 32'(quantum_left), 32'd4);
    check_eq("r5_no_troca", 32'(troca_contexto), 32'h0);
    check_eq("r5_no_resume", 32'(resume_valid), 32'h0);
    check_eq("r5_proc_kept", 32'(proc_atual), 32'h0);
    sched_enable = 1'b1;
    wait_switch(50, cnt);
    check_eq("r5_resume_cnt", 32'(cnt), 32'd4);
    pc_atual = 32'h500; pc_sel = 2'd0;
    tick();
    check_eq("r5_saved_pc", pc_rdata, 32'h501);

    // Resume request in KERNEL while disabled is dropped.
    sched_enable = 1'b0;
    do_resume(2'd1);
    check_eq("k_drop_valid", 32'(resume_valid), 32'h0);
    check_eq("k_drop_kmode", 32'(kernel_mode), 32'h1);
    sched_enable = 1'b1;

    // PC+1 wraps to zero on save.
    write_q(16'd1);
    do_resume(2'd0);
    tick();
    check_eq("wrap_troca", 32'(troca_contexto), 32'h3);
    pc_atual = 32'hFFFF_FFFF;
    tick();
    check_eq("wrap_saved", pc_rdata, 32'h0);

    // Asynchronous reset in the middle of SWITCH.
    do_resume(2'd2);
    tick();
    check_eq("ar_troca_pre", 32'(troca_contexto), 32'h3);
    reset = 1'b0;
    #1;
    check_eq("ar_troca", 32'(troca_contexto), 32'h0);
    check_eq("ar_kmode", 32'(kernel_mode), 32'h1);
    check_eq("ar_qleft", 32'(quantum_left), 32'h0);
    check_eq("ar_proc", 32'(proc_atual), 32'h0);
    check_eq("ar_rpc", resume_pc, 32'h0);
    pc_sel = 2'd2;
    #1;
    check_eq("ar_table2", pc_rdata, 32'h0);
    pc_sel = 2'd1;
    #1;
    check_eq("ar_table1", pc_rdata, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    do_resume(2'd3);
    check_eq("ar_default_q", 32'(quantum_left), 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
